// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg
// Shared pixel-path types for the grayscale-word to RGB stream converter:
//   gray_t         8-bit grayscale sample
//   rgb_t          24-bit packed RGB pixel, R in [23:16], G in [15:8], B in [7:0]
//   color_mode_e   colour mapping applied to each grayscale sample
//   LANES_PER_WORD number of gray pixels packed in one 32-bit input word
// ---------------------------------------------------------------------------
package pixel_pkg;

  typedef logic [7:0] gray_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_INV  = 2'd1,
    MODE_HEAT = 2'd2
  } color_mode_e;

  localparam int LANES_PER_WORD = 4;

  // The raw 2-bit mode input has one spare code (3); it falls back to a
  // plain gray replicate so the datapath never sees an undefined mode.
  function automatic color_mode_e decode_mode(input logic [1:0] raw);
    color_mode_e mode;
    case (raw)
      2'd1:    mode = MODE_INV;
      2'd2:    mode = MODE_HEAT;
      default: mode = MODE_GRAY;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/gray_word_to_rgb_stream_if.sv
// ---------------------------------------------------------------------------
// gray_word_to_rgb_stream_if
// Bundles the two stream ports of the converter.
//   Input word stream : s_data_i[31:0] (pixel 0 in [7:0]), s_user_i (start of
//                       frame), s_valid_i, s_ready_o
//   Output pixel stream: m_rgb_o (rgb_t), m_user_o (first pixel of frame),
//                       m_last_o (last pixel of line), m_valid_o, m_ready_i
// Modports:
//   slave  - the converter: sinks words, sources pixels
//   master - the environment: sources words, sinks pixels
// Signal names keep the converter-side _i/_o suffixes on both modports.
// ---------------------------------------------------------------------------
interface gray_word_to_rgb_stream_if;
  import pixel_pkg::*;

  logic [31:0] s_data_i;
  logic        s_user_i;
  logic        s_valid_i;
  logic        s_ready_o;

  rgb_t        m_rgb_o;
  logic        m_user_o;
  logic        m_last_o;
  logic        m_valid_o;
  logic        m_ready_i;

  modport slave (
    input  s_data_i, s_user_i, s_valid_i, m_ready_i,
    output s_ready_o, m_rgb_o, m_user_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_user_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_rgb_o, m_user_o, m_last_o, m_valid_o
  );

endinterface

// File: rtl/gray_colormap.sv
// ---------------------------------------------------------------------------
// gray_colormap
// Purely combinational colour mapping of one grayscale sample.
//   gray_i  gray sample
//   mode_i  MODE_GRAY -> (g,g,g), MODE_INV -> (~g,~g,~g),
//           MODE_HEAT -> two-segment false colour (only when COLOR_EN=1,
//           otherwise identical to MODE_GRAY)
//   rgb_o   mapped pixel
// ---------------------------------------------------------------------------
module gray_colormap
  import pixel_pkg::*;
#(
  parameter bit COLOR_EN = 1'b1
) (
  input  gray_t       gray_i,
  input  color_mode_e mode_i,
  output rgb_t        rgb_o
);

  // Heat ramp: the low seven bits, doubled, sweep each half of the range.
  // Lower half fades blue -> green, upper half fades green -> red.
  logic [7:0] ramp;

  always_comb begin
    ramp  = {gray_i[6:0], 1'b0};
    rgb_o = '{r: gray_i, g: gray_i, b: gray_i};
    case (mode_i)
      MODE_INV: begin
        rgb_o = '{r: ~gray_i, g: ~gray_i, b: ~gray_i};
      end
      MODE_HEAT: begin
        if (COLOR_EN) begin
          if (gray_i[7]) begin
            rgb_o = '{r: ramp, g: ~ramp, b: 8'h00};
          end else begin
            rgb_o = '{r: 8'h00, g: ramp, b: ~ramp};
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/gray_word_to_rgb_stream.sv
// ---------------------------------------------------------------------------
// gray_word_to_rgb_stream
// Unpacks 32-bit words of four grayscale pixels into a stream of 24-bit RGB
// pixels, one pixel per output beat, and marks line ends / frame starts.
//   clk_i, rst_i  clock and synchronous active-high reset
//   mode_i        colour mode, sampled with each accepted word
//   sync_err_o    one-cycle pulse when a start-of-frame word lands mid-line
//   bus (slave)   s_* word input stream, m_* pixel output stream
// Parameters:
//   LINE_WIDTH    pixels per line; a multiple of 4, at least 4
//   COLOR_EN      1 enables the heat false-colour mode
// ---------------------------------------------------------------------------
module gray_word_to_rgb_stream
  import pixel_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter bit COLOR_EN   = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 mode_i,
  output logic                       sync_err_o,
  gray_word_to_rgb_stream_if.slave   bus
);

  localparam int              COL_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q,    state_d;
  logic [31:0]       word_q,     word_d;
  logic              user_q,     user_d;
  color_mode_e       mode_q,     mode_d;
  logic [1:0]        lane_q,     lane_d;
  logic [COL_W-1:0]  col_q,      col_d;
  logic              sync_err_q, sync_err_d;
  logic              ready_en_q, ready_en_d;

  // Split the held word into its four pixel lanes.
  gray_t lane_px [LANES_PER_WORD];

  genvar gi;
  for (gi = 0; gi < LANES_PER_WORD; gi++) begin : g_lane
    assign lane_px[gi] = word_q[gi*8 +: 8];
  end

  rgb_t cur_rgb;

  gray_colormap #(
    .COLOR_EN (COLOR_EN)
  ) u_colormap (
    .gray_i (lane_px[lane_q]),
    .mode_i (mode_q),
    .rgb_o  (cur_rgb)
  );

  logic             full;
  logic             lane_last;
  logic             m_xfer;
  logic             s_ready;
  logic             s_xfer;
  logic [COL_W-1:0] col_inc;
  logic [COL_W-1:0] load_col;

  always_comb begin
    full      = (state_q == ST_FULL);
    lane_last = (lane_q == 2'd3);
    m_xfer    = full & bus.m_ready_i;
    // ready_en_q holds the input closed for the first cycle after reset.
    // In FULL the next word is taken only as the last lane leaves, so a
    // stalled output also stalls the input.
    s_ready   = ready_en_q &
                ((state_q == ST_EMPTY) | (full & lane_last & bus.m_ready_i));
    s_xfer    = bus.s_valid_i & s_ready;
    col_inc   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    // Column the new word's lane 0 would occupy: when chaining from lane 3
    // the counter is advancing past that last pixel in the same edge.
    load_col  = full ? col_inc : col_q;
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    user_d     = user_q;
    mode_d     = mode_q;
    lane_d     = lane_q;
    col_d      = col_q;
    sync_err_d = 1'b0;
    ready_en_d = 1'b1;

    case (state_q)
      ST_EMPTY: begin
        if (s_xfer) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (m_xfer) begin
          col_d = col_inc;
          if (lane_last) begin
            lane_d = 2'd0;
            if (!s_xfer) begin
              state_d = ST_EMPTY;
            end
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Word load is shared by the EMPTY accept and the back-to-back chain.
    if (s_xfer) begin
      word_d = bus.s_data_i;
      user_d = bus.s_user_i;
      mode_d = decode_mode(mode_i);
      lane_d = 2'd0;
      if (bus.s_user_i) begin
        col_d      = '0;
        sync_err_d = (load_col != '0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      word_q     <= '0;
      user_q     <= 1'b0;
      mode_q     <= MODE_GRAY;
      lane_q     <= 2'd0;
      col_q      <= '0;
      sync_err_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      user_q     <= user_d;
      mode_q     <= mode_d;
      lane_q     <= lane_d;
      col_q      <= col_d;
      sync_err_q <= sync_err_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Outputs are gated by FULL so nothing but zeros is visible while empty.
  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = full;
  assign bus.m_rgb_o   = full ? cur_rgb : '0;
  assign bus.m_user_o  = full & user_q & (lane_q == 2'd0);
  assign bus.m_last_o  = full & (col_q == COL_LAST);
  assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_gray_word_to_rgb_stream.sv
// ---------------------------------------------------------------------------
// tb_gray_word_to_rgb_stream
// Two converters with LINE_WIDTH=8 share one stimulus: dut_a has the heat
// mode enabled, dut_b has it disabled. Colour mapping is checked from a
// table of hand-computed vectors; streaming, backpressure, frame sync and
// reset behaviour are checked with directed sequences.
// ---------------------------------------------------------------------------
module tb_gray_word_to_rgb_stream;
  import pixel_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       sync_err_a;
  logic       sync_err_b;

  gray_word_to_rgb_stream_if bus_a ();
  gray_word_to_rgb_stream_if bus_b ();

  assign bus_b.s_data_i  = bus_a.s_data_i;
  assign bus_b.s_user_i  = bus_a.s_user_i;
  assign bus_b.s_valid_i = bus_a.s_valid_i;
  assign bus_b.m_ready_i = bus_a.m_ready_i;

  gray_word_to_rgb_stream #(
    .LINE_WIDTH (8),
    .COLOR_EN   (1'b1)
  ) dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .mode_i     (mode),
    .sync_err_o (sync_err_a),
    .bus        (bus_a)
  );

  gray_word_to_rgb_stream #(
    .LINE_WIDTH (8),
    .COLOR_EN   (1'b0)
  ) dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .mode_i     (mode),
    .sync_err_o (sync_err_b),
    .bus        (bus_b)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [1:0]       mode;
    logic [31:0]      word;
    logic [3:0][23:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int k);
    return 8'(k * 7 + 3);
  endfunction

  function automatic logic [31:0] word_of(input int w);
    return {pix(4*w+3), pix(4*w+2), pix(4*w+1), pix(4*w)};
  endfunction

  function automatic logic [31:0] rep(input int k);
    return {8'h00, pix(k), pix(k), pix(k)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus_a.s_valid_i = 1'b0;
    bus_a.s_user_i  = 1'b0;
    bus_a.m_ready_i = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  // Streams n_words gray-replicate words with s_valid held high and checks
  // every output beat against the pixel index k it should be showing.
  task automatic run_stream(input string tag, input int n_words, input logic [7:0] user_mask,
                            input bit rand_ready, input int last_a, input int last_b,
                            input int user_b, input int err_at);
    int  w;
    int  k;
    int  cyc;
    bit  fresh;
    bit  in_acc;
    bit  out_acc;
    int  total;
    total = n_words * 4;
    w = 0;
    k = 0;
    fresh = 1'b1;
    mode = 2'd0;
    bus_a.s_valid_i = 1'b1;
    bus_a.s_data_i  = word_of(0);
    bus_a.s_user_i  = user_mask[0];
    bus_a.m_ready_i = 1'b0;
    step();
    w = 1;
    bus_a.s_data_i = word_of(1);
    bus_a.s_user_i = user_mask[1];
    if (n_words < 2) begin
      bus_a.s_valid_i = 1'b0;
      bus_a.s_user_i  = 1'b0;
    end
    cyc = 0;
    while (k < total && cyc < 400) begin
      check($sformatf("%s valid k=%0d", tag, k), 32'(bus_a.m_valid_o), 32'd1);
      check($sformatf("%s rgb k=%0d", tag, k), {8'h00, bus_a.m_rgb_o}, rep(k));
      check($sformatf("%s user k=%0d", tag, k), 32'(bus_a.m_user_o),
            32'((k == 0) || (k == user_b)));
      check($sformatf("%s last k=%0d", tag, k), 32'(bus_a.m_last_o),
            32'((k == last_a) || (k == last_b)));
      check($sformatf("%s sync_err k=%0d", tag, k), 32'(sync_err_a),
            32'(fresh && (k == err_at)));
      bus_a.m_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      check($sformatf("%s s_ready k=%0d", tag, k), 32'(bus_a.s_ready_o),
            32'(bus_a.m_ready_i && (k % 4 == 3)));
      in_acc  = bus_a.s_valid_i && bus_a.s_ready_o;
      out_acc = bus_a.m_ready_i;
      step();
      fresh = out_acc;
      if (out_acc) k++;
      if (in_acc) begin
        w++;
        if (w < n_words) begin
          bus_a.s_data_i = word_of(w);
          bus_a.s_user_i = user_mask[w];
        end else begin
          bus_a.s_valid_i = 1'b0;
          bus_a.s_user_i  = 1'b0;
        end
      end
      cyc++;
    end
    check($sformatf("%s pixels delivered", tag), 32'(k), 32'(total));
    check($sformatf("%s valid after end", tag), 32'(bus_a.m_valid_o), 32'd0);
    check($sformatf("%s sync_err after end", tag), 32'(sync_err_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcount;
    logic [7:0] g;

    vecs[0] = '{2'd0, 32'h03020100, {24'h030303, 24'h020202, 24'h010101, 24'h000000}};
    vecs[1] = '{2'd1, 32'h03020100, {24'hFCFCFC, 24'hFDFDFD, 24'hFEFEFE, 24'hFFFFFF}};
    vecs[2] = '{2'd2, 32'hFF807F00, {24'hFE0100, 24'h00FF00, 24'h00FE01, 24'h0000FF}};
    vecs[3] = '{2'd3, 32'hA5C35A10, {24'hA5A5A5, 24'hC3C3C3, 24'h5A5A5A, 24'h101010}};
    vecs[4] = '{2'd2, 32'h40C01020, {24'h00807F, 24'h807F00, 24'h0020DF, 24'h0040BF}};

    // Reset state.
    bus_a.s_data_i  = 32'h0;
    bus_a.s_user_i  = 1'b0;
    bus_a.s_valid_i = 1'b0;
    bus_a.m_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    check("reset m_valid", 32'(bus_a.m_valid_o), 32'd0);
    check("reset m_rgb", {8'h00, bus_a.m_rgb_o}, 32'h0);
    check("reset m_user", 32'(bus_a.m_user_o), 32'd0);
    check("reset m_last", 32'(bus_a.m_last_o), 32'd0);
    check("reset sync_err", 32'(sync_err_a), 32'd0);
    check("reset s_ready", 32'(bus_a.s_ready_o), 32'd0);
    rst = 1'b0;
    step();
    check("s_ready after reset", 32'(bus_a.s_ready_o), 32'd1);
    check("m_valid after reset", 32'(bus_a.m_valid_o), 32'd0);

    // Colour-map vectors, one isolated word each; mode_i is disturbed while
    // the word drains and must not affect it.
    bus_a.m_ready_i = 1'b1;
    for (int v = 0; v < 5; v++) begin
      mode = vecs[v].mode;
      bus_a.s_data_i  = vecs[v].word;
      bus_a.s_valid_i = 1'b1;
      step();
      bus_a.s_valid_i = 1'b0;
      mode = vecs[v].mode ^ 2'd1;
      for (int l = 0; l < 4; l++) begin
        check($sformatf("vec%0d lane%0d valid", v, l), 32'(bus_a.m_valid_o), 32'd1);
        check($sformatf("vec%0d lane%0d rgb", v, l), {8'h00, bus_a.m_rgb_o},
              {8'h00, vecs[v].exp[l]});
        if (vecs[v].mode == 2'd2) begin
          g = vecs[v].word[l*8 +: 8];
          check($sformatf("vec%0d lane%0d rgb no-heat", v, l), {8'h00, bus_b.m_rgb_o},
                {8'h00, g, g, g});
        end
        step();
      end
      check($sformatf("vec%0d valid drops", v), 32'(bus_a.m_valid_o), 32'd0);
    end

    // Back-to-back words at full rate over two lines.
    do_reset();
    run_stream("b2b", 4, 8'b0000_0001, 1'b0, 7, 15, -1, -1);

    // Random output backpressure over two lines.
    do_reset();
    run_stream("bp", 4, 8'b0000_0001, 1'b1, 7, 15, -1, -1);

    // Start of frame on the second word of a line realigns the column.
    do_reset();
    run_stream("sync", 3, 8'b0000_0011, 1'b0, 11, -1, 4, 4);

    // Reset while lane 2 is stalled: remaining lanes must never appear.
    do_reset();
    mode = 2'd0;
    bus_a.m_ready_i = 1'b1;
    bus_a.s_data_i  = 32'h44332211;
    bus_a.s_user_i  = 1'b1;
    bus_a.s_valid_i = 1'b1;
    step();
    bus_a.s_valid_i = 1'b0;
    bus_a.s_user_i  = 1'b0;
    step();
    step();
    check("midrst lane2 rgb", {8'h00, bus_a.m_rgb_o}, 32'h00333333);
    bus_a.m_ready_i = 1'b0;
    rst = 1'b1;
    step();
    check("midrst m_valid", 32'(bus_a.m_valid_o), 32'd0);
    check("midrst m_rgb", {8'h00, bus_a.m_rgb_o}, 32'h0);
    check("midrst m_user", 32'(bus_a.m_user_o), 32'd0);
    check("midrst m_last", 32'(bus_a.m_last_o), 32'd0);
    check("midrst sync_err", 32'(sync_err_a), 32'd0);
    check("midrst s_ready", 32'(bus_a.s_ready_o), 32'd0);
    rst = 1'b0;
    bus_a.m_ready_i = 1'b1;
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus_a.m_valid_o) vcount++;
    end
    check("midrst no leftover lanes", 32'(vcount), 32'd0);
    check("midrst s_ready recovers", 32'(bus_a.s_ready_o), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
